// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter enable controller: FSM encoding and default sizing.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    StStopped = 2'd0,
    StRunning = 2'd1,
    StStep    = 2'd2
  } ctrl_state_e;

  localparam int unsigned DefSyncStages     = 2;
  localparam int unsigned DefDebounceCycles = 4;
  localparam int unsigned DefPrescaleW      = 8;

  // Bits needed to hold a counter that runs 0 .. max_val-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/counter_enable_ctrl_if.sv
// Button inputs, prescale setting and counter-drive outputs of the enable controller.
interface counter_enable_ctrl_if
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned PRESCALE_W = DefPrescaleW
);

  logic                  btn_run;
  logic                  btn_clear;
  logic                  btn_step;
  logic [PRESCALE_W-1:0] prescale;
  logic                  enable;
  logic                  counter_reset;
  logic                  running;

  // Whoever presses the buttons and watches the counter drive.
  modport master (
    output btn_run,
    output btn_clear,
    output btn_step,
    output prescale,
    input  enable,
    input  counter_reset,
    input  running
  );

  // The controller itself.
  modport slave (
    input  btn_run,
    input  btn_clear,
    input  btn_step,
    input  prescale,
    output enable,
    output counter_reset,
    output running
  );

endinterface

// File: rtl/btn_debounce.sv
// Synchroniser plus debouncer for one raw push-button; emits the clean level and a
// registered one-cycle pulse on every accepted 0->1 change.
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned    CntW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Metastability chain: raw enters at bit 0 and leaves at the top bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Count consecutive disagreeing samples; flip the level when the run is long enough.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_out != level_q) begin
      if (cnt_q == LastCnt) begin
        level_d = sync_out;
        rise_d  = sync_out;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/counter_enable_ctrl.sv
// Run/stop/step controller producing a prescaled enable pulse and a clear pulse for the
// downstream 4-bit counter. All outputs come straight from flops.
module counter_enable_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned PRESCALE_W      = DefPrescaleW
) (
  input logic                  clock,
  input logic                  reset,
  counter_enable_ctrl_if.slave bus
);

  logic run_rise, clear_rise, step_rise;
  logic run_level, clear_level, step_level;

  // Levels are not needed by the controller; only the rising pulses drive it.
  logic unused_levels;
  assign unused_levels = ^{run_level, clear_level, step_level};

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_db (
    .clock(clock),
    .reset(reset),
    .raw  (bus.btn_run),
    .level(run_level),
    .rise (run_rise)
  );

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_db (
    .clock(clock),
    .reset(reset),
    .raw  (bus.btn_clear),
    .level(clear_level),
    .rise (clear_rise)
  );

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clock(clock),
    .reset(reset),
    .raw  (bus.btn_step),
    .level(step_level),
    .rise (step_rise)
  );

  ctrl_state_e           state_q, state_d;
  logic [PRESCALE_W-1:0] tick_q, tick_d;
  logic                  enable_q, enable_d;
  logic                  counter_reset_q, counter_reset_d;
  logic                  running_q;

  // State register, tick counter and output flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StStopped;
      tick_q          <= '0;
      enable_q        <= 1'b0;
      counter_reset_q <= 1'b1;
      running_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      tick_q          <= tick_d;
      enable_q        <= enable_d;
      counter_reset_q <= counter_reset_d;
      running_q       <= (state_d == StRunning);
    end
  end

  // Next state: clear swallows run/step events; STEP always lasts a single cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStopped: begin
        if (!clear_rise) begin
          if (run_rise) begin
            state_d = StRunning;
          end else if (step_rise) begin
            state_d = StStep;
          end
        end
      end
      StRunning: begin
        if (!clear_rise && run_rise) begin
          state_d = StStopped;
        end
      end
      StStep:  state_d = StStopped;
      default: state_d = StStopped;
    endcase
  end

  // Outputs and prescaler. The step pulse is launched on entry to STEP so it is
  // high for exactly the cycle the FSM spends there.
  always_comb begin
    enable_d        = 1'b0;
    counter_reset_d = 1'b0;
    tick_d          = tick_q;
    if (clear_rise) begin
      counter_reset_d = 1'b1;
      tick_d          = '0;
    end else begin
      unique case (state_q)
        StStopped: begin
          if (run_rise) begin
            tick_d = '0;
          end else if (step_rise) begin
            enable_d = 1'b1;
          end
        end
        StRunning: begin
          if (run_rise) begin
            tick_d = '0;
          end else if (tick_q >= bus.prescale) begin
            // >= rather than == so lowering prescale below tick wraps on the next edge.
            enable_d = 1'b1;
            tick_d   = '0;
          end else begin
            tick_d = tick_q + PRESCALE_W'(1);
          end
        end
        StStep:  tick_d = tick_q;
        default: tick_d = '0;
      endcase
    end
  end

  assign bus.enable        = enable_q;
  assign bus.counter_reset = counter_reset_q;
  assign bus.running       = running_q;

endmodule

// File: tb/tb_counter_enable_ctrl.sv
// Directed bench for counter_enable_ctrl (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, PRESCALE_W=8).
// Window indices count clock edges from the moment a button is pressed; with a held
// press the debounced rise lands on edge 6 and the controller reacts on edge 7.
module tb_counter_enable_ctrl;

  localparam int unsigned PrescaleW = 8;
  localparam int MaskRun   = 1;
  localparam int MaskClear = 2;
  localparam int MaskStep  = 4;

  logic clock;
  logic reset;

  counter_enable_ctrl_if #(.PRESCALE_W(PrescaleW)) ctrl_if ();

  counter_enable_ctrl #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .PRESCALE_W     (PrescaleW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (ctrl_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Press the buttons in mask for hold edges, observe n edges and summarise the outputs.
  task automatic press_watch(input int mask, input int hold, input int n,
                             output int en_cnt, output int cr_cnt, output int run_hi,
                             output int first_en, output int first_cr, output int en_after_cr,
                             output int first_run, output int coincide);
    en_cnt = 0; cr_cnt = 0; run_hi = 0; coincide = 0;
    first_en = -1; first_cr = -1; en_after_cr = -1; first_run = -1;
    ctrl_if.btn_run   = (mask & MaskRun) != 0;
    ctrl_if.btn_clear = (mask & MaskClear) != 0;
    ctrl_if.btn_step  = (mask & MaskStep) != 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock);
      #1;
      if (i == hold) begin
        ctrl_if.btn_run   = 1'b0;
        ctrl_if.btn_clear = 1'b0;
        ctrl_if.btn_step  = 1'b0;
      end
      if (ctrl_if.enable) begin
        en_cnt++;
        if (first_en < 0) first_en = i;
        if (first_cr >= 0 && en_after_cr < 0) en_after_cr = i;
      end
      if (ctrl_if.counter_reset) begin
        cr_cnt++;
        if (first_cr < 0) first_cr = i;
        if (ctrl_if.enable) coincide++;
      end
      if (ctrl_if.running) begin
        run_hi++;
        if (first_run < 0) first_run = i;
      end
    end
  endtask

  int en_cnt, cr_cnt, run_hi, first_en, first_cr, en_after_cr, first_run, coincide;

  initial begin
    reset             = 1'b1;
    ctrl_if.btn_run   = 1'b0;
    ctrl_if.btn_clear = 1'b0;
    ctrl_if.btn_step  = 1'b0;
    ctrl_if.prescale  = 8'd3;

    // 1. Reset values, release, idle.
    #1;
    check_val("rst_counter_reset", ctrl_if.counter_reset, 1);
    check_val("rst_enable", ctrl_if.enable, 0);
    check_val("rst_running", ctrl_if.running, 0);
    tick_clk(2);
    reset = 1'b0;
    #1;
    check_val("cr_held_until_edge", ctrl_if.counter_reset, 1);
    tick_clk(1);
    check_val("cr_drop_after_edge", ctrl_if.counter_reset, 0);
    press_watch(0, 0, 50, en_cnt, cr_cnt, run_hi, first_en, first_cr, en_after_cr,
                first_run, coincide);
    check_val("idle_enable_cnt", en_cnt, 0);
    check_val("idle_running_cnt", run_hi, 0);
    check_val("idle_cr_cnt", cr_cnt, 0);

    // 2. Held run button, prescale 3.
    press_watch(MaskRun, 100, 24, en_cnt, cr_cnt, run_hi, first_en, first_cr, en_after_cr,
                first_run, coincide);
    check_val("run_latency", first_run, 7);
    check_val("first_enable", first_en, 11);
    check_val("enable_pulses_p3", en_cnt, 4);
    ctrl_if.btn_run = 1'b0;
    tick_clk(12);

    // 3. Clear glitch rejected, then a real clear.
    press_watch(MaskClear, 3, 15, en_cnt, cr_cnt, run_hi, first_en, first_cr, en_after_cr,
                first_run, coincide);
    check_val("clear_glitch_cr", cr_cnt, 0);
    check_val("clear_glitch_run", run_hi, 15);
    press_watch(MaskClear, 6, 20, en_cnt, cr_cnt, run_hi, first_en, first_cr, en_after_cr,
                first_run, coincide);
    check_val("clear_cr_cnt", cr_cnt, 1);
    check_val("clear_cr_edge", first_cr, 7);
    check_val("clear_next_enable", en_after_cr, 11);
    check_val("clear_no_coincide", coincide, 0);
    check_val("clear_running_kept", run_hi, 20);

    // 4. Stop, single-step three times, then step while running.
    press_watch(MaskRun, 8, 20, en_cnt, cr_cnt, run_hi, first_en, first_cr, en_after_cr,
                first_run, coincide);
    check_val("stop_running_cycles", run_hi, 6);
    tick_clk(5);
    for (int k = 0; k < 3; k++) begin
      press_watch(MaskStep, 8, 20, en_cnt, cr_cnt, run_hi, first_en, first_cr, en_after_cr,
                  first_run, coincide);
      check_val($sformatf("step%0d_pulses", k), en_cnt, 1);
      check_val($sformatf("step%0d_edge", k), first_en, 7);
      check_val($sformatf("step%0d_running", k), run_hi, 0);
    end
    ctrl_if.prescale = 8'd255;
    press_watch(MaskRun, 8, 20, en_cnt, cr_cnt, run_hi, first_en, first_cr, en_after_cr,
                first_run, coincide);
    check_val("restart_latency", first_run, 7);
    press_watch(MaskStep, 8, 20, en_cnt, cr_cnt, run_hi, first_en, first_cr, en_after_cr,
                first_run, coincide);
    check_val("step_while_running", en_cnt, 0);
    check_val("step_keeps_running", run_hi, 20);

    // 5. Run and clear together while stopped; prescale 0 gives an enable every cycle.
    press_watch(MaskRun, 8, 20, en_cnt, cr_cnt, run_hi, first_en, first_cr, en_after_cr,
                first_run, coincide);
    check_val("stop2_running_cycles", run_hi, 6);
    press_watch(MaskRun | MaskClear, 8, 20, en_cnt, cr_cnt, run_hi, first_en, first_cr,
                en_after_cr, first_run, coincide);
    check_val("run_clear_cr_cnt", cr_cnt, 1);
    check_val("run_clear_running", run_hi, 0);
    check_val("run_clear_enable", en_cnt, 0);
    ctrl_if.prescale = 8'd0;
    press_watch(MaskRun, 8, 20, en_cnt, cr_cnt, run_hi, first_en, first_cr, en_after_cr,
                first_run, coincide);
    check_val("p0_run_latency", first_run, 7);
    check_val("p0_first_enable", first_en, 8);
    check_val("p0_enable_cnt", en_cnt, 13);

    // 6. Asynchronous reset two ticks into a prescale-7 period.
    ctrl_if.prescale = 8'd7;
    tick_clk(2);
    check_val("pre_reset_running", ctrl_if.running, 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_rst_running", ctrl_if.running, 0);
    check_val("async_rst_enable", ctrl_if.enable, 0);
    check_val("async_rst_cr", ctrl_if.counter_reset, 1);
    #2;
    reset = 1'b0;
    press_watch(0, 0, 30, en_cnt, cr_cnt, run_hi, first_en, first_cr, en_after_cr,
                first_run, coincide);
    check_val("post_rst_running", run_hi, 0);
    check_val("post_rst_enable", en_cnt, 0);
    check_val("post_rst_cr", cr_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
